uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 73 +++++++
 tb/tb_uart_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready byte output.
// Ports: clk, rst (async, active-high); rx serial line (idle high);
//        data/valid/ready byte handshake; busy while a frame is in progress;
//        frame_err and overrun are single-cycle pulses.
module uart_rx #(
    parameter int CLOCK_RATE_HZ   = 100_000_000,
    parameter int BAUD_RATE_HZ    = 115_200,
    parameter int CLOCKS_PER_BAUD = CLOCK_RATE_HZ / BAUD_RATE_HZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);
    typedef enum logic [3:0] {
        IDLE, START, DATA0, DATA1, DATA2, DATA3, DATA4, DATA5, DATA6, DATA7, STOP, BREAK
    } state_t;
    localparam logic [31:0] HALF = 32'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [31:0] FULL = 32'(CLOCKS_PER_BAUD - 1);
    state_t      state, state_nx;
    logic [31:0] cnt;
    logic [7:0]  shift;
    logic        meta0, meta1, rx_s;
    logic        strobe, in_data, load_half, load_full, stop_ok, deliver, drop, stop_bad;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {meta0, meta1, rx_s} <= 3'b111;
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            {meta0, meta1, rx_s} <= {rx, meta0, meta1};
            state     <= state_nx;
            cnt       <= load_half ? HALF : load_full ? FULL : (cnt != 0) ? cnt - 32'd1 : cnt;
            shift     <= (in_data && strobe) ? {rx_s, shift[7:1]} : shift;
            data      <= deliver ? shift : data;
            valid     <= deliver | (valid & ~ready);
            frame_err <= stop_bad;
            overrun   <= drop;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = rx_s ? IDLE : START;
            START:   state_nx = strobe ? (rx_s ? IDLE : DATA0) : START;
            STOP:    state_nx = strobe ? (rx_s ? IDLE : BREAK) : STOP;
            BREAK:   state_nx = rx_s ? IDLE : BREAK;
            default: state_nx = strobe ? state_t'(state + 4'd1) : state;
        endcase
    end
    always_comb begin
        strobe    = cnt == 0;
        in_data   = state >= DATA0 && state <= DATA7;
        load_half = state == IDLE && !rx_s;
        load_full = strobe && ((state == START && !rx_s) || in_data);
        stop_ok   = state == STOP && strobe && rx_s;
        stop_bad  = state == STOP && strobe && !rx_s;
        // a consumer taking the old byte this cycle frees the slot for the new one
        deliver   = stop_ok && (!valid || ready);
        drop      = stop_ok && valid && !ready;
        busy      = state != IDLE;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at 8 clocks per bit.
module tb_uart_rx;
    logic       clk, rst, rx, ready;
    logic [7:0] data;
    logic       valid, busy, frame_err, overrun;
    int         checks = 0, failures = 0;
    int         fe_cnt = 0, ov_cnt = 0, fe0, ov0;

    uart_rx #(.CLOCK_RATE_HZ(8_000_000), .BAUD_RATE_HZ(1_000_000), .CLOCKS_PER_BAUD(8)) dut (
        .clk(clk), .rst(rst), .rx(rx), .ready(ready), .data(data),
        .valid(valid), .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start bit plus 8 data bits, LSB first; call at a negedge
    task automatic send_head(input logic [7:0] b);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rx = bits[i];
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_head(b);
        rx = stop;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst = 1; rx = 1; ready = 0;
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 0;
        repeat (5) @(negedge clk);

        // 0xA5, ready held high: valid appears after edge 79 for one cycle
        ready = 1; fe0 = fe_cnt; ov0 = ov_cnt;
        send_head(8'hA5);
        rx = 1;
        repeat (7) @(negedge clk);
        check("a5_valid_early", valid, 0);
        @(negedge clk);
        check("a5_valid", valid, 1);
        check("a5_data", data, 8'hA5);
        @(negedge clk);
        check("a5_valid_clr", valid, 0);
        check("a5_ferr", fe_cnt - fe0, 0);
        check("a5_ovr", ov_cnt - ov0, 0);
        ready = 0;
        repeat (4) @(negedge clk);

        // two-cycle glitch: START entered, then aborted at the half-bit strobe
        rx = 0;
        repeat (2) @(negedge clk);
        rx = 1;
        repeat (2) @(negedge clk);
        check("glitch_busy", busy, 1);
        repeat (5) @(negedge clk);
        check("glitch_idle", busy, 0);
        repeat (10) @(negedge clk);
        check("glitch_valid", valid, 0);

        // 0x3C with a low stop bit: frame_err, then BREAK until the line returns high
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        @(negedge clk);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_valid", valid, 0);
        check("fe_break_busy", busy, 1);
        rx = 1;
        repeat (5) @(negedge clk);
        check("fe_idle", busy, 0);
        check("fe_single", fe_cnt - fe0, 1);

        // 0x01 then 0xFF with ready low: first byte held, second dropped with overrun
        ov0 = ov_cnt; fe0 = fe_cnt;
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        @(negedge clk);
        check("ovr_data", data, 8'h01);
        check("ovr_valid", valid, 1);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_ferr", fe_cnt - fe0, 0);
        ready = 1;
        @(negedge clk);
        ready = 0;
        check("ovr_clr", valid, 0);
        repeat (3) @(negedge clk);

        // 0x55 then 0x0F, ready high only at the second stop strobe: new byte replaces old
        ov0 = ov_cnt;
        send_frame(8'h55, 1'b1);
        check("bb_first", data, 8'h55);
        send_head(8'h0F);
        rx = 1;
        repeat (7) @(negedge clk);
        ready = 1;
        @(negedge clk);
        ready = 0;
        check("bb_data", data, 8'h0F);
        check("bb_valid", valid, 1);
        @(negedge clk);
        check("bb_valid_hold", valid, 1);
        check("bb_no_ovr", ov_cnt - ov0, 0);
        ready = 1;
        @(negedge clk);
        ready = 0;
        repeat (3) @(negedge clk);

        // 0x99 aborted by reset in DATA4, then 0x42 received normally
        rx = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h99 >> i) & 1;
            repeat (8) @(negedge clk);
        end
        rx = 1;
        repeat (4) @(negedge clk);
        check("rst_mid_busy_pre", busy, 1);
        #2 rst = 1;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_valid", valid, 0);
        @(negedge clk);
        rst = 0;
        repeat (100) @(negedge clk);
        check("rst_no_deliver", valid, 0);
        check("rst_idle", busy, 0);
        send_frame(8'h42, 1'b1);
        check("after_rst_data", data, 8'h42);
        check("after_rst_valid", valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
